// File: rtl/i2s_seq_pkg.sv
// Shared definitions for the I2S wave sequencer: FSM encoding, ROM sample width,
// channel codes and the wave-position stepping helpers.
package i2s_seq_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_LEFT  = 2'd2;
  localparam logic [1:0] S_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    LOAD  = S_LOAD,
    LEFT  = S_LEFT,
    RIGHT = S_RIGHT
  } seq_state_t;

  localparam int ROM_WIDTH = 16;

  localparam logic LEFT_CH  = 1'b0;
  localparam logic RIGHT_CH = 1'b1;

  // A zero-length table behaves as a single-entry table pinned at address 0.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

  function automatic logic [7:0] next_pos(input logic [7:0] pos, input logic [7:0] len);
    logic [8:0] inc;
    inc = {1'b0, pos} + 9'd1;
    return (inc >= {1'b0, eff_len(len)}) ? 8'd0 : inc[7:0];
  endfunction

endpackage

// File: rtl/i2s_wave_sequencer.sv
// Steps through the test-tone ROM and offers each sample to the I2S writer as a
// left/right pair over valid/ready, with optional mute and arithmetic attenuation.
module i2s_wave_sequencer
  import i2s_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   mute,
  input  logic [3:0]             volume_shift,
  input  logic [7:0]             wave_length,
  input  logic [15:0]            wave_value,
  output logic [7:0]             wave_pos,
  output logic [DATA_WIDTH-1:0]  sample_data,
  output logic                   sample_channel,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic                   busy
);

  seq_state_t             state_q, state_d;
  logic [7:0]             wave_pos_q, wave_pos_d;
  logic [DATA_WIDTH-1:0]  sample_data_q, sample_data_d;
  logic                   sample_channel_q, sample_channel_d;
  logic                   sample_valid_q, sample_valid_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                   busy_q, busy_d;

  logic signed [ROM_WIDTH-1:0] wave_s;
  logic signed [ROM_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0]       justified_s;

  // Attenuate the ROM word, then sign-extend and left-justify it into the output width.
  always_comb begin
    wave_s      = wave_value;
    shifted_s   = wave_s >>> volume_shift;
    justified_s = DATA_WIDTH'(shifted_s) << (DATA_WIDTH - ROM_WIDTH);
  end

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d          = state_q;
    wave_pos_d       = wave_pos_q;
    sample_data_d    = sample_data_q;
    sample_channel_d = sample_channel_q;
    sample_valid_d   = sample_valid_q;
    frame_count_d    = frame_count_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // A shrunk table leaves the address out of range: rewind first and
        // capture from address 0 on the following cycle.
        if (wave_pos_q >= eff_len(wave_length)) begin
          wave_pos_d = 8'd0;
          state_d    = LOAD;
        end else begin
          sample_data_d    = mute ? {DATA_WIDTH{1'b0}} : justified_s;
          sample_channel_d = LEFT_CH;
          sample_valid_d   = 1'b1;
          state_d          = LEFT;
        end
      end
      LEFT: begin
        if (sample_ready) begin
          sample_channel_d = RIGHT_CH;
          state_d          = RIGHT;
        end else begin
          state_d = LEFT;
        end
      end
      RIGHT: begin
        if (sample_ready) begin
          frame_count_d    = frame_count_q + COUNT_WIDTH'(1'b1);
          wave_pos_d       = next_pos(wave_pos_q, wave_length);
          sample_valid_d   = 1'b0;
          sample_channel_d = LEFT_CH;
          state_d          = enable ? LOAD : IDLE;
        end else begin
          state_d = RIGHT;
        end
      end
      default: begin
        sample_valid_d   = 1'b0;
        sample_channel_d = LEFT_CH;
        state_d          = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      wave_pos_q       <= 8'd0;
      sample_data_q    <= {DATA_WIDTH{1'b0}};
      sample_channel_q <= LEFT_CH;
      sample_valid_q   <= 1'b0;
      frame_count_q    <= {COUNT_WIDTH{1'b0}};
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      wave_pos_q       <= wave_pos_d;
      sample_data_q    <= sample_data_d;
      sample_channel_q <= sample_channel_d;
      sample_valid_q   <= sample_valid_d;
      frame_count_q    <= frame_count_d;
      busy_q           <= busy_d;
    end
  end

  assign wave_pos       = wave_pos_q;
  assign sample_data    = sample_data_q;
  assign sample_channel = sample_channel_q;
  assign sample_valid   = sample_valid_q;
  assign frame_count    = frame_count_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_i2s_wave_sequencer.sv
// Self-checking bench for i2s_wave_sequencer: a sine tone ROM, a frame-level
// reference model, a datapath vector table and hand-written corner sequences.
module tb_i2s_wave_sequencer;

  localparam int DW = 24;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          mute;
  logic [3:0]    volume_shift;
  logic [7:0]    wave_length;
  logic [15:0]   wave_value;
  logic [7:0]    wave_pos;
  logic [DW-1:0] sample_data;
  logic          sample_channel;
  logic          sample_valid;
  logic          sample_ready;
  logic [CW-1:0] frame_count;
  logic          busy;

  always #5 clk = ~clk;

  i2s_wave_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mute(mute),
    .volume_shift(volume_shift), .wave_length(wave_length),
    .wave_value(wave_value), .wave_pos(wave_pos),
    .sample_data(sample_data), .sample_channel(sample_channel),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .frame_count(frame_count), .busy(busy)
  );

  logic [15:0] rom [256];
  logic        tbl_mode;
  logic [15:0] tbl_val;
  assign wave_value = tbl_mode ? tbl_val : rom[wave_pos];

  int errors = 0;
  int checks = 0;

  // Reference model state: position/frames as the spec defines them, plus the
  // half of the frame expected next and the data the whole frame must carry.
  int          pos_m, frame_m;
  bit          half_m;
  logic [23:0] cur_exp;
  bit          post_right, post_rst, hold_pending;
  logic [23:0] hold_data;
  bit          hold_ch;
  logic [23:0] lefts [$];
  int          cyc, first_left_cyc, last_right_cyc;
  bit          xv, xch;
  logic [23:0] xd;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  sh;
    logic        mu;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_sample(input logic [15:0] v, input int sh, input bit m);
    int s, d, q;
    if (m) return 24'h0;
    s = int'($signed(v));
    d = 1 << sh;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return 24'(q * 256);
  endfunction

  function automatic logic [15:0] val_at(input int p);
    return tbl_mode ? tbl_val : rom[p];
  endfunction

  // Called at a negedge with inputs already set: checks outputs, feeds the model, advances one cycle.
  task automatic tick();
    int eff;
    xv  = 1'b0;
    eff = (wave_length == 8'd0) ? 1 : int'(wave_length);
    if (post_rst) begin
      check("rst_ctl", {sample_valid, busy, sample_channel, wave_pos}, 64'd0);
      check("rst_data_frames", {sample_data, frame_count}, 64'd0);
      post_rst = 1'b0;
    end
    if (post_right) begin
      check("pos_after_frame", wave_pos, 64'(pos_m));
      check("frame_count", frame_count, 64'(frame_m));
      post_right = 1'b0;
    end
    if (hold_pending) begin
      check("hold_while_stalled", {sample_valid, sample_channel, sample_data}, {1'b1, hold_ch, hold_data});
      hold_pending = 1'b0;
    end
    if (rst) begin
      pos_m = 0; frame_m = 0; half_m = 1'b0; post_rst = 1'b1;
      lefts.delete();
    end else if (sample_valid) begin
      if (sample_ready) begin
        xv = 1'b1; xch = sample_channel; xd = sample_data;
        if (!half_m) begin
          if (pos_m >= eff) pos_m = 0;
          cur_exp = exp_sample(val_at(pos_m), int'(volume_shift), mute);
          check("left_channel", sample_channel, 64'd0);
          check("left_data", sample_data, cur_exp);
          if (lefts.size() == 0) first_left_cyc = cyc;
          lefts.push_back(sample_data);
          half_m = 1'b1;
        end else begin
          check("right_channel", sample_channel, 64'd1);
          check("right_data", sample_data, cur_exp);
          frame_m = frame_m + 1;
          pos_m = (pos_m + 1 >= eff) ? 0 : pos_m + 1;
          half_m = 1'b0;
          post_right = 1'b1;
          last_right_cyc = cyc;
        end
      end else begin
        hold_pending = 1'b1; hold_ch = sample_channel; hold_data = sample_data;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; sample_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain();
    enable = 1'b0; sample_ready = 1'b1;
    repeat (8) tick();
    check("drain_idle", {busy, sample_valid}, 64'd0);
  endtask

  task automatic run_until_frames(input int n, input int budget);
    int k = 0;
    while (frame_m < n && k < budget) begin
      tick();
      k++;
    end
    check("frames_reached", 64'(frame_m), 64'(n));
  endtask

  // One frame from IDLE with enable dropped while LEFT is on offer.
  task automatic one_frame();
    bit got = 1'b0;
    enable = 1'b1; sample_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (sample_valid && !sample_channel) enable = 1'b0;
      tick();
      if (xv && xch) begin
        got = 1'b1;
        break;
      end
    end
    enable = 1'b0;
    check("frame_completed", got, 64'd1);
    check("idle_after_disable", busy, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    real r;
    for (int i = 0; i < 256; i++) begin
      if (i < 44) begin
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * i / 44.0);
        rom[i] = (r >= 0.0) ? 16'($rtoi(r + 0.5)) : 16'(-$rtoi(0.5 - r));
      end else begin
        rom[i] = 16'($urandom);
      end
    end
    vecs[0] = '{16'h7FFF, 4'd0,  1'b0, 24'h7FFF00};
    vecs[1] = '{16'h8000, 4'd0,  1'b0, 24'h800000};
    vecs[2] = '{16'h8000, 4'd15, 1'b0, 24'hFFFF00};
    vecs[3] = '{16'hEDC9, 4'd4,  1'b0, 24'hFEDC00};
    vecs[4] = '{16'h0001, 4'd1,  1'b0, 24'h000000};
    vecs[5] = '{16'hFFFF, 4'd1,  1'b0, 24'hFFFF00};
    vecs[6] = '{16'h1234, 4'd0,  1'b1, 24'h000000};
    vecs[7] = '{16'h4000, 4'd2,  1'b0, 24'h100000};
    vecs[8] = '{16'h7FFF, 4'd15, 1'b0, 24'h000000};

    tbl_mode = 1'b0; tbl_val = 16'h0;
    mute = 1'b0; volume_shift = 4'd0; wave_length = 8'd44;
    rst = 1'b1; enable = 1'b0; sample_ready = 1'b0;
    cyc = 0; pos_m = 0; frame_m = 0; half_m = 1'b0;
    post_right = 1'b0; post_rst = 1'b0; hold_pending = 1'b0;
    @(negedge clk);

    // Reset, then idle with enable low.
    tick(); tick();
    rst = 1'b0;
    repeat (20) begin
      check("idle_ctl", {sample_valid, busy, sample_channel, wave_pos}, 64'd0);
      check("idle_data_frames", {sample_data, frame_count}, 64'd0);
      tick();
    end

    // Tone ROM with ready held high: latency, pinned samples, wrap and throughput.
    enable = 1'b1; sample_ready = 1'b1;
    tick();
    check("latency_load", {busy, sample_valid}, 64'b10);
    tick();
    check("latency_valid", {sample_valid, sample_channel}, 64'b10);
    run_until_frames(44, 200);
    check("wrap_pos", wave_pos, 64'd0);
    check("wrap_frames", frame_count, 64'd44);
    check("rom_frame1", lefts[0], 64'h000000);
    check("rom_frame2", lefts[1], 64'h123700);
    check("rom_frame12", lefts[11], 64'h7FFF00);
    check("throughput", 64'(last_right_cyc - first_left_cyc), 64'd130);
    drain();

    // Datapath vector table; the table word is presented at every address.
    tbl_mode = 1'b1; wave_length = 8'd1;
    for (int i = 0; i < 9; i++) begin
      tbl_val = vecs[i].val; volume_shift = vecs[i].sh; mute = vecs[i].mu;
      one_frame();
      check("tbl_left", lefts[lefts.size()-1], 64'(vecs[i].exp));
      check("tbl_right", xd, 64'(vecs[i].exp));
    end
    tbl_mode = 1'b0;

    // Random backpressure and enable, with settings changed only while idle.
    for (int blk = 0; blk < 4; blk++) begin
      wave_length  = 8'($urandom_range(0, 50));
      volume_shift = 4'($urandom_range(0, 6));
      mute         = ($urandom_range(0, 3) == 0);
      repeat (150) begin
        enable       = ($urandom_range(0, 7) != 0);
        sample_ready = 1'($urandom_range(0, 1));
        tick();
      end
      drain();
    end

    // Attenuation at position 23, then mute, with disable/re-enable between frames.
    do_reset();
    mute = 1'b0; volume_shift = 4'd0; wave_length = 8'd44;
    enable = 1'b1; sample_ready = 1'b1;
    run_until_frames(22, 200);
    drain();
    check("resume_pos23", wave_pos, 64'd23);
    volume_shift = 4'd4;
    one_frame();
    check("shift4_pos23", lefts[lefts.size()-1], 64'hFEDC00);
    mute = 1'b1; volume_shift = 4'd0;
    one_frame();
    check("mute_data", xd, 64'h0);
    check("mute_pos_advances", wave_pos, 64'd25);
    mute = 1'b0;

    // Shrinking the table at position 40 rewinds to 0 with a two-cycle LOAD.
    do_reset();
    wave_length = 8'd44; enable = 1'b1; sample_ready = 1'b1;
    run_until_frames(39, 200);
    drain();
    check("pos40", wave_pos, 64'd40);
    wave_length = 8'd10; enable = 1'b1;
    tick();
    check("shrink_load1", {busy, sample_valid, wave_pos}, {1'b1, 1'b0, 8'd40});
    tick();
    check("shrink_load2", {busy, sample_valid, wave_pos}, {1'b1, 1'b0, 8'd0});
    tick();
    check("shrink_valid", {sample_valid, sample_channel}, 64'b10);
    one_frame();
    check("shrink_next_pos", wave_pos, 64'd1);

    // Zero length pins the position at 0.
    wave_length = 8'd0;
    repeat (3) one_frame();
    check("len0_pos", wave_pos, 64'd0);

    // Reset while RIGHT is on offer: the frame is not counted.
    wave_length = 8'd44; enable = 1'b1; sample_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (sample_valid && sample_channel) break;
      tick();
    end
    check("reach_right", {sample_valid, sample_channel}, 64'b11);
    sample_ready = 1'b0;
    check("rst_prior_frames", frame_count, 64'(frame_m));
    rst = 1'b1; sample_ready = 1'b1;
    tick();
    check("rst_in_right_frames", frame_count, 64'd0);
    rst = 1'b0; enable = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
